// File: rtl/dcache_pkg.sv
// Shared types and address-field width helpers for the direct-mapped data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        FILL = 2'd2
    } state_t;

    localparam int ADDR_W = 32;

    function automatic int offset_w(input int wpb);
        return $clog2(wpb);
    endfunction

    function automatic int index_w(input int sets);
        return $clog2(sets);
    endfunction

    // Tag is whatever remains above byte, word-select and index bits.
    function automatic int tag_w(input int sets, input int wpb);
        return ADDR_W - 2 - $clog2(sets) - $clog2(wpb);
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/data storage: one combinational read port, one word write port,
// synchronous tag+valid set and asynchronous valid clear.
module dcache_array #(
    parameter int NUM_SETS = 64,
    parameter int WPB      = 4,
    parameter int TAG_W    = 24
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [$clog2(NUM_SETS)-1:0] rd_idx_i,
    input  logic [$clog2(WPB)-1:0]      rd_sel_i,
    output logic [TAG_W-1:0]            rd_tag_o,
    output logic                        rd_valid_o,
    output logic [31:0]                 rd_data_o,
    input  logic                        wr_en_i,
    input  logic [$clog2(NUM_SETS)-1:0] wr_idx_i,
    input  logic [$clog2(WPB)-1:0]      wr_sel_i,
    input  logic [31:0]                 wr_data_i,
    input  logic                        set_en_i,
    input  logic [$clog2(NUM_SETS)-1:0] set_idx_i,
    input  logic [TAG_W-1:0]            set_tag_i
);

    logic [TAG_W-1:0]    tag_q   [NUM_SETS];
    logic [31:0]         data_q  [NUM_SETS][WPB];
    logic [NUM_SETS-1:0] valid_q;

    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i][rd_sel_i];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) data_q[wr_idx_i][wr_sel_i] <= wr_data_i;
        if (set_en_i) tag_q[set_idx_i] <= set_tag_i;
    end

    // Only the valid bits need reset; stale tag/data are masked by valid=0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) valid_q <= '0;
        else if (set_en_i) valid_q[set_idx_i] <= 1'b1;
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller between
// the MEM stage and dmem: same-cycle load hits, stalled line refill on load miss.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_SETS        = 64,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int MEM_LAT         = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_re,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wd,
    output logic [31:0] cpu_rd,
    output logic        stall,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam int OFF_W  = offset_w(WORDS_PER_BLOCK);
    localparam int IDX_W  = index_w(NUM_SETS);
    localparam int TAG_W  = tag_w(NUM_SETS, WORDS_PER_BLOCK);
    localparam int BLK_W  = IDX_W + TAG_W;
    localparam int CNT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int LAT_M1 = (MEM_LAT > 0) ? MEM_LAT - 1 : 0;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [OFF_W-1:0] fill_q;
    logic [BLK_W-1:0] base_q;

    logic [OFF_W-1:0] req_sel;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [TAG_W-1:0] line_tag;
    logic             line_valid;
    logic [31:0]      line_word;
    logic             hit, miss, in_idle, in_fill;
    logic             unused_byte;

    assign req_sel     = cpu_addr[2 +: OFF_W];
    assign req_idx     = cpu_addr[2 + OFF_W +: IDX_W];
    assign req_tag     = cpu_addr[31 -: TAG_W];
    assign unused_byte = ^cpu_addr[1:0];

    assign in_idle = (state_q == IDLE);
    assign in_fill = (state_q == FILL);
    assign hit     = line_valid && (line_tag == req_tag);
    // A simultaneous load+store is a store, so only a pure load can miss.
    assign miss    = in_idle && cpu_re && !cpu_we && !hit;

    assign stall    = !rst && (miss || !in_idle);
    assign mem_we   = !rst && in_idle && cpu_we;
    assign mem_wd   = rst ? '0 : cpu_wd;
    assign cpu_rd   = rst ? '0 : line_word;
    assign mem_addr = rst     ? '0 :
                      in_fill ? {2'b00, base_q, fill_q} :
                                {2'b00, cpu_addr[31:2]};

    dcache_array #(
        .NUM_SETS (NUM_SETS),
        .WPB      (WORDS_PER_BLOCK),
        .TAG_W    (TAG_W)
    ) u_array (
        .clk_i      (clk),
        .rst_i      (rst),
        .rd_idx_i   (req_idx),
        .rd_sel_i   (req_sel),
        .rd_tag_o   (line_tag),
        .rd_valid_o (line_valid),
        .rd_data_o  (line_word),
        .wr_en_i    (in_fill || (in_idle && cpu_we && hit)),
        .wr_idx_i   (in_fill ? base_q[IDX_W-1:0] : req_idx),
        .wr_sel_i   (in_fill ? fill_q : req_sel),
        .wr_data_i  (in_fill ? mem_rd : cpu_wd),
        .set_en_i   (in_fill && (fill_q == OFF_W'(WORDS_PER_BLOCK - 1))),
        .set_idx_i  (base_q[IDX_W-1:0]),
        .set_tag_i  (base_q[BLK_W-1:IDX_W])
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fill_q  <= '0;
            base_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (miss) begin
                    base_q  <= cpu_addr[31 -: BLK_W];
                    cnt_q   <= '0;
                    fill_q  <= '0;
                    state_q <= (MEM_LAT == 0) ? FILL : WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(LAT_M1)) state_q <= FILL;
                end
                FILL: begin
                    fill_q <= fill_q + 1'b1;
                    if (fill_q == OFF_W'(WORDS_PER_BLOCK - 1)) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed scoreboard bench for dcache_ctrl: stimulus queues expected loads,
// stores and miss stalls; a negedge monitor pops and compares.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_re = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wd = '0;
    logic [31:0] cpu_rd, mem_addr, mem_wd, mem_rd;
    logic        stall, mem_we;

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk(clk), .rst(rst), .cpu_re(cpu_re), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wd(cpu_wd), .cpu_rd(cpu_rd), .stall(stall),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    // dmem model: word i initialised to 0xD0000000 | i, aliased on low 10 bits.
    logic [31:0] dm [1024];
    assign mem_rd = dm[mem_addr[9:0]];

    initial begin
        for (int i = 0; i < 1024; i++) dm[i] = 32'hD000_0000 | 32'(i);
        forever begin
            @(posedge clk);
            if (mem_we && !rst) dm[mem_addr[9:0]] = mem_wd;
        end
    end

    typedef struct {
        int          len;
        logic [31:0] base;
        int          nw;
    } miss_t;

    logic [31:0] ld_q [$];
    logic [63:0] st_q [$];
    miss_t       ms_q [$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: load data, store writes and stall runs (with the refill addresses).
    initial begin
        int          run;
        logic [31:0] hist [4];
        logic [63:0] e;
        miss_t       m;
        run = 0;
        for (int i = 0; i < 4; i++) hist[i] = '0;
        forever begin
            @(negedge clk);
            if (!rst && cpu_re && !cpu_we && !stall) begin
                if (ld_q.size() == 0) check("ld_pending", ld_q.size(), 1);
                else check("load_data", cpu_rd, ld_q.pop_front());
            end
            if (mem_we) begin
                if (st_q.size() == 0) check("st_pending", st_q.size(), 1);
                else begin
                    e = st_q.pop_front();
                    check("st_addr", mem_addr, e[63:32]);
                    check("st_wd", mem_wd, e[31:0]);
                end
            end
            if (stall) begin
                run++;
                hist[0] = hist[1]; hist[1] = hist[2]; hist[2] = hist[3];
                hist[3] = mem_addr;
            end else if (run > 0) begin
                if (ms_q.size() == 0) check("miss_pending", ms_q.size(), 1);
                else begin
                    m = ms_q.pop_front();
                    check("stall_len", run, m.len);
                    for (int k = 0; k < m.nw; k++)
                        check("fill_addr", hist[4 - m.nw + k], m.base + 32'(k));
                end
                run = 0;
            end
        end
    end

    task automatic push_miss(input int len, input logic [31:0] base, input int nw);
        miss_t m;
        m.len = len; m.base = base; m.nw = nw;
        ms_q.push_back(m);
    endtask

    task automatic wait_free(input string nm);
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (!stall) done = 1'b1;
        end
        if (!done) check(nm, {31'b0, stall}, 32'h0);
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] exp);
        ld_q.push_back(exp);
        @(posedge clk); #1;
        cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = a;
        wait_free("load_timeout");
        @(posedge clk); #1;
        cpu_re = 1'b0;
    endtask

    task automatic do_miss(input logic [31:0] a, input logic [31:0] exp, input logic [31:0] base);
        push_miss(25, base, 4);
        do_load(a, exp);
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] waddr, input logic also_re);
        st_q.push_back({waddr, d});
        @(posedge clk); #1;
        cpu_we = 1'b1; cpu_re = also_re; cpu_addr = a; cpu_wd = d;
        @(posedge clk); #1;
        cpu_we = 1'b0; cpu_re = 1'b0;
    endtask

    initial begin
        int n;
        // Reset with a store+load request asserted: every output must stay zero.
        cpu_re = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wd = 32'h1234;
        #12;
        check("rst_stall", {31'b0, stall}, 32'h0);
        check("rst_mem_we", {31'b0, mem_we}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wd", mem_wd, 32'h0);
        check("rst_cpu_rd", cpu_rd, 32'h0);
        @(posedge clk); #1;
        cpu_re = 1'b0; cpu_we = 1'b0; rst = 1'b0;

        do_miss(32'h40, 32'hD000_0010, 32'h10);              // cold miss
        do_load(32'h44, 32'hD000_0011);                      // hit
        do_load(32'h4C, 32'hD000_0013);                      // last word hit
        do_store(32'h44, 32'hF, 32'h11, 1'b0);               // store hit
        do_load(32'h44, 32'hF);
        do_store(32'h400, 32'hA, 32'h100, 1'b0);             // store miss, no allocate
        do_miss(32'h400, 32'hA, 32'h100);
        do_load(32'h40, 32'hD000_0010);                      // conflict pair
        do_miss(32'h440, 32'hD000_0110, 32'h110);
        do_miss(32'h40, 32'hD000_0010, 32'h10);
        do_store(32'h48, 32'h55, 32'h12, 1'b1);              // re+we acts as store
        do_load(32'h48, 32'h55);
        do_miss(32'hFFFF_FFF0, 32'hD000_03FC, 32'h3FFF_FFFC); // top of address space
        do_load(32'hFFFF_FFFC, 32'hD000_03FF);

        // Reset while word 2 of the refill is on the bus.
        push_miss(24, 32'h20, 3);
        push_miss(25, 32'h20, 4);
        ld_q.push_back(32'hD000_0020);
        @(posedge clk); #1;
        cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80;
        n = 0;
        for (int i = 0; i < 200 && n < 24; i++) begin
            @(negedge clk);
            if (stall) n++;
        end
        check("fill_w2_addr", mem_addr, 32'h22);
        #1 rst = 1'b1;
        #1;
        check("midrst_stall", {31'b0, stall}, 32'h0);
        check("midrst_mem_addr", mem_addr, 32'h0);
        check("midrst_cpu_rd", cpu_rd, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        wait_free("reload_timeout");
        @(posedge clk); #1;
        cpu_re = 1'b0;

        do_miss(32'h40, 32'hD000_0010, 32'h10);              // valid bits were cleared

        repeat (3) @(posedge clk);
        check("ld_q_left", ld_q.size(), 0);
        check("st_q_left", st_q.size(), 0);
        check("ms_q_left", ms_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
